wb_sram_bank_bridge: RTL
========================

// Module: wb_sram_bank_bridge
// PURPOSE
//  Wishbone slave bridging the management SoC bus to NUM_BANKS single-port (port 0)
//  sky130 OpenRAM macros, 32 x 2^ADDR_W words each. Replaces direct bus-to-macro wiring:
//  - generates registered active-low csb/web and byte wmask;
//  - tracks the macro read latency and returns a proper single-cycle wbs_ack_o.
//  Sits inside user_project_wrapper, between the WB MI A port and the SRAM instances.
// PARAMETERS
//  NUM_BANKS  2             number of SRAM macros, power of 2, >=1
//  ADDR_W     8             word-address bits per macro (256 words)
//  DATA_W     32            data width; wmask width = DATA_W/8
//  READ_LAT   2             wb_clk_i edges from macro sampling csb to valid dout0, 1..7
// PORTS
//  wb_clk_i      in   1                   bus/SRAM clock; macros are clocked by the same net
//  wb_rst_ni     in   1                   reset, asynchronous, active-low
//  wbs_cyc_i     in   1                   WB cycle
//  wbs_stb_i     in   1                   WB strobe
//  wbs_we_i      in   1                   1 = write
//  wbs_sel_i     in   DATA_W/8            byte selects
//  wbs_adr_i     in   32                  byte address; word = [ADDR_W+1:2]
//                                         bank = [ADDR_W+1+BANK_W:ADDR_W+2]
//  wbs_dat_i     in   DATA_W              write data
//  wbs_ack_o     out  1                   single-cycle acknowledge
//  wbs_dat_o     out  DATA_W              read data, valid with ack
//  wbs_err_o     out  1                   error strobe (see CONFIGURATION)
//  sram_csb0_o   out  NUM_BANKS           per-bank chip select, active-low
//  sram_web0_o   out  1                   shared write enable, active-low
//  sram_wmask0_o out  DATA_W/8            shared byte write mask
//  sram_addr0_o  out  ADDR_W              shared word address
//  sram_din0_o   out  DATA_W              shared write data
//  sram_dout0_i  in   NUM_BANKS*DATA_W    per-bank read data, bank b at [b*DATA_W +: DATA_W]
//  busy_o        out  1                   high whenever FSM != IDLE
// BEHAVIOUR
//  BANK_W = $clog2(NUM_BANKS); BANK_W = 0 gives a single bank and no bank field.
//  Reset (async, wb_rst_ni=0) values:
//   - sram_csb0_o all 1, sram_web0_o=1, wmask/addr/din=0;
//   - wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, busy_o=0; FSM=IDLE.
//  FSM states:
//   - IDLE: on cyc&stb at edge E0:
//     - latch bank, address, we, sel, data;
//     - drive csb[bank]=0, web=~we, wmask=we?sel:0 for exactly one cycle;
//     - -> WRITE if we, else -> RWAIT.
//   - WRITE: macro samples at E1; ack registered at E1 (high E1..E2); -> ACK.
//   - RWAIT: csb returns high at E1; down-counter loaded READ_LAT at E1.
//     At E1+READ_LAT, wbs_dat_o <= dout0 of latched bank, ack=1; -> ACK.
//   - ACK: ack high this cycle only; -> IDLE. No request accepted in ACK, so a
//     master still holding stb during ack never triggers a second access.
//  Latency, request sample to ack edge: write 1, read 1+READ_LAT.
//  wbs_dat_o holds last read value until next read completes; not changed by writes.
//  wbs_sel_i=0 write: access performed with wmask=0 (memory unchanged), still acked.
//  stb high with cyc low: ignored.
//  cyc dropped in RWAIT/WRITE: FSM -> IDLE next edge, no ack; write already sampled stays committed.
//  Reset asserted mid-access: immediate return to reset values; macro access in flight may complete.
//  Only one outstanding access; no pipelining.
// CONFIGURATION
//  WB_SRAM_BRIDGE_ERR_EN defined:
//   - wbs_adr_i[31:ADDR_W+2+BANK_W] != 0 is out of range;
//   - no csb asserted; wbs_err_o pulses one cycle at E1 instead of ack; -> ACK path.
//  Not defined:
//   - upper address bits ignored (aliasing/wrap modulo NUM_BANKS*2^ADDR_W words);
//   - wbs_err_o tied 0.
// TESTING
//  1. Reset: hold wb_rst_ni=0 mid-read
//     -> all csb=1, ack=0, dat_o=0, busy_o=0 asynchronously.
//  2. Write 0xDEADBEEF to 0x0000_0010 sel=4'hF; read back
//     -> csb0[0] low 1 cycle, wmask=F, addr=4;
//     -> write ack 1 edge after request; read ack 3 edges after request (READ_LAT=2), dat_o=0xDEADBEEF.
//  3. Byte write 0x000000AA sel=4'h1 over 0xDEADBEEF, then read
//     -> dat_o=0xDEADBEAA; sel=0 write -> ack, data unchanged.
//  4. Bank select: write 0x11111111 to 0x0000_0400, 0x22222222 to 0x0000_0000 (ADDR_W=8, 2 banks)
//     -> csb0[1] then csb0[0]; reads return 0x11111111 / 0x22222222.
//  5. Master holds stb for 2 cycles after ack
//     -> exactly one csb pulse per transaction; cyc dropped in RWAIT -> no ack, busy_o=0 next cycle.
//  6. ERR_EN on: read 0x0000_0800 -> err 1 cycle, ack never, no csb low.
//     ERR_EN off: same read aliases to bank0 word0 -> returns 0x22222222 with ack.

Source files
------------

// File: rtl/wb_sram_bank_bridge_if.sv
// Wishbone slave-side signal bundle between the management SoC bus and wb_sram_bank_bridge.
// The master modport is the bus side; the slave modport is the bridge side.
interface wb_sram_bank_bridge_if #(
  parameter int DATA_W = 32
);
  logic                wbs_cyc_i;
  logic                wbs_stb_i;
  logic                wbs_we_i;
  logic [DATA_W/8-1:0] wbs_sel_i;
  logic [31:0]         wbs_adr_i;
  logic [DATA_W-1:0]   wbs_dat_i;
  logic                wbs_ack_o;
  logic [DATA_W-1:0]   wbs_dat_o;
  logic                wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o, wbs_err_o
  );
endinterface

// File: rtl/wb_sram_bank_bridge.sv
// Wishbone slave driving NUM_BANKS single-port OpenRAM macros with registered csb/web/wmask.
// Optional macro WB_SRAM_BRIDGE_ERR_EN: out-of-range addresses return wbs_err_o instead of aliasing.
module wb_sram_bank_bridge #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  wb_sram_bank_bridge_if.slave        wbs,
  output logic [NUM_BANKS-1:0]        sram_csb0_o,
  output logic                        sram_web0_o,
  output logic [DATA_W/8-1:0]         sram_wmask0_o,
  output logic [ADDR_W-1:0]           sram_addr0_o,
  output logic [DATA_W-1:0]           sram_din0_o,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0_i,
  output logic                        busy_o
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int MAP_W  = ADDR_W + 2 + BANK_W;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RWAIT,
    ERRW,
    ACK
  } state_t;

  state_t            state;
  logic [BSEL_W-1:0] bank_in;
  logic [BSEL_W-1:0] bank_q;
  logic [CNT_W-1:0]  cnt;
  logic              req;
  logic              out_of_range;
  logic              unused_adr_bits;

  assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign busy_o = (state != IDLE);

  generate
    if (BANK_W > 0) begin : g_bank
      assign bank_in = wbs.wbs_adr_i[ADDR_W+2 +: BANK_W];
    end else begin : g_nobank
      assign bank_in = '0;
    end
  endgenerate

`ifdef WB_SRAM_BRIDGE_ERR_EN
  assign out_of_range = (wbs.wbs_adr_i >> MAP_W) != 32'd0;
`else
  assign out_of_range = 1'b0;
`endif

  // Byte-offset bits, and the upper bits when aliasing, take no part in decoding.
  assign unused_adr_bits = ^{wbs.wbs_adr_i[31:MAP_W], wbs.wbs_adr_i[1:0]};

  // Strobes default back to idle every edge, so each accepted request gives exactly one macro cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      bank_q        <= '0;
      cnt           <= '0;
      sram_csb0_o   <= '1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_err_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      sram_csb0_o   <= '1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            bank_q       <= bank_in;
            sram_addr0_o <= wbs.wbs_adr_i[ADDR_W+1:2];
            sram_din0_o  <= wbs.wbs_dat_i;
            cnt          <= '0;
            if (out_of_range) begin
              state <= ERRW;
            end else begin
              sram_csb0_o   <= ~(NUM_BANKS'(1) << bank_in);
              sram_web0_o   <= ~wbs.wbs_we_i;
              sram_wmask0_o <= wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
              state         <= wbs.wbs_we_i ? WRITE : RWAIT;
            end
          end
        end
        WRITE: begin
          if (!wbs.wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            wbs.wbs_ack_o <= 1'b1;
            state         <= ACK;
          end
        end
        ERRW: begin
          if (!wbs.wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            wbs.wbs_err_o <= 1'b1;
            state         <= ACK;
          end
        end
        RWAIT: begin
          // cnt == 0 marks the edge where the macro samples csb; the countdown starts there.
          if (!wbs.wbs_cyc_i) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            cnt <= CNT_W'(READ_LAT);
          end else if (cnt == CNT_W'(1)) begin
            wbs.wbs_dat_o <= sram_dout0_i[bank_q*DATA_W +: DATA_W];
            wbs.wbs_ack_o <= 1'b1;
            state         <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_bank: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    $onehot0(~sram_csb0_o));
  a_ack_err_excl: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    !(wbs.wbs_ack_o && wbs.wbs_err_o));
  a_ack_pulse: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    wbs.wbs_ack_o |=> !wbs.wbs_ack_o);
  a_web_with_csb: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    !sram_web0_o |-> !(&sram_csb0_o));
`endif

endmodule
